fifo_rd_unpacker: RTL and testbench

FIFO_RD_UNPACKER -- requirements
Module: fifo_rd_unpacker

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/fifo_rd_unpacker_word_buf2.sv | 80 ++++++++
 rtl/fifo_rd_unpacker.sv | 109 ++++++++++
 tb/tb_fifo_rd_unpacker.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared defaults and helpers for the FIFO read-side unpacker.
//                Holds the default word/lane/counter widths, the derived lane
//                ratio and lane-index width, and the buffer occupancy type.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int IN_BIT_DEF  = 64;
  localparam int OUT_BIT_DEF = 16;
  localparam int CNT_BIT_DEF = 16;
  localparam int RATIO_DEF   = IN_BIT_DEF / OUT_BIT_DEF;
  localparam int LANE_W_DEF  = $clog2(RATIO_DEF);

  // Occupancy of the two-entry word buffer (0..2).
  typedef logic [1:0] occ_t;

  // Number of output lanes carried by one FIFO word.
  function automatic int lane_ratio(input int in_bit, input int out_bit);
    return in_bit / out_bit;
  endfunction

  // Width of the lane index; never narrower than one bit.
  function automatic int lane_width(input int ratio);
    return (ratio < 2) ? 1 : $clog2(ratio);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_unpacker_word_buf2.sv
`default_nettype none
// ============================================================================
//  Module      : word_buf2
//  Description : Two-entry in-order word queue with synchronous flush.
//  Ports       : rclk/rrst  - clock, async active-high reset
//                flush      - clears the queue (push/pop ignored that cycle)
//                push/push_data - enqueue a word
//                pop        - dequeue the head word
//                head       - oldest stored word
//                count      - number of stored words (0..2)
//  Revision    : 1.0 - initial release
// ============================================================================
module word_buf2
  import fifo_pkg::*;
#(
  parameter int W = IN_BIT_DEF
) (
  input  logic         rclk,
  input  logic         rrst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output occ_t         count
);

  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  occ_t         count_q, count_d;

  always_comb begin
    ent0_d   = ent0_q;
    ent1_d   = ent1_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = '0;
    end else begin
      if (push) begin
        if (wr_ptr_q) ent1_d = push_data;
        else          ent0_d = push_data;
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      // Push and pop together leave the count unchanged; pointers keep order.
      count_d = count_q + occ_t'(push) - occ_t'(pop);
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      ent0_q   <= '0;
      ent1_q   <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      ent0_q   <= ent0_d;
      ent1_q   <= ent1_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = rd_ptr_q ? ent1_q : ent0_q;
  assign count = count_q;

  // The credit logic upstream must never push into a full queue.
  a_no_overflow: assert property (@(posedge rclk) disable iff (rrst)
    !(push && !pop && !flush && count_q == 2'd2));

endmodule
`default_nettype wire

// File: rtl/fifo_rd_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_unpacker
//  Description : Reads IN_BIT words from an async FIFO read channel and emits
//                them as RATIO lanes of OUT_BIT bits, lane 0 = LSBs, with a
//                valid/ready handshake. Reads are credit-limited so the
//                two-word buffer can never overflow.
//  Ports       : rclk, rrst          - clock, async active-high reset
//                fifo_ren            - FIFO read request
//                fifo_rdata          - FIFO data, valid one cycle after a read
//                fifo_rempty         - FIFO empty flag
//                flush               - discard buffered and in-flight words
//                out_valid/out_ready - lane handshake
//                out_data/out_last   - current lane / last lane of its word
//                word_cnt            - fully consumed words, wrapping
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_unpacker
  import fifo_pkg::*;
#(
  parameter int IN_BIT  = IN_BIT_DEF,
  parameter int OUT_BIT = OUT_BIT_DEF,
  parameter int CNT_BIT = CNT_BIT_DEF
) (
  input  logic               rclk,
  input  logic               rrst,
  output logic               fifo_ren,
  input  logic [IN_BIT-1:0]  fifo_rdata,
  input  logic               fifo_rempty,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_BIT-1:0] out_data,
  output logic               out_last,
  output logic [CNT_BIT-1:0] word_cnt
);

  localparam int                RATIO     = lane_ratio(IN_BIT, OUT_BIT);
  localparam int                LANE_W    = lane_width(RATIO);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  logic               inflight_q, inflight_d;
  logic [LANE_W-1:0]  lane_q, lane_d;
  logic [CNT_BIT-1:0] word_cnt_q, word_cnt_d;

  logic [IN_BIT-1:0]              head;
  logic [RATIO-1:0][OUT_BIT-1:0]  head_lanes;
  occ_t                           occ;
  logic                           push;
  logic                           pop;
  logic                           handshake;
  logic [2:0]                     credit;

  assign head_lanes = head;

  always_comb begin
    out_valid = (occ != 2'd0);
    handshake = out_valid & out_ready;
    out_last  = out_valid & (lane_q == LAST_LANE);
    out_data  = out_valid ? head_lanes[lane_q] : '0;
    pop       = handshake & (lane_q == LAST_LANE);
    // A word arriving during flush belongs to the discarded stream.
    push      = inflight_q & ~flush;

    // Words still held after this cycle's pop plus the one on its way in.
    credit    = {1'b0, occ - occ_t'(pop)} + {2'b00, inflight_q};
    fifo_ren  = ~rrst & ~flush & (credit < 3'd2);

    inflight_d = fifo_ren & ~fifo_rempty;

    lane_d = lane_q;
    if (flush) begin
      lane_d = '0;
    end else if (handshake) begin
      lane_d = (lane_q == LAST_LANE) ? '0 : lane_q + LANE_W'(1);
    end

    word_cnt_d = word_cnt_q + CNT_BIT'(pop);
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      inflight_q <= 1'b0;
      lane_q     <= '0;
      word_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      lane_q     <= lane_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign word_cnt = word_cnt_q;

  word_buf2 #(
    .W (IN_BIT)
  ) u_word_buf2 (
    .rclk      (rclk),
    .rrst      (rrst),
    .flush     (flush),
    .push      (push),
    .push_data (fifo_rdata),
    .pop       (pop),
    .head      (head),
    .count     (occ)
  );

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_rd_unpacker
//  Description : Self-checking bench for fifo_rd_unpacker. A FIFO model feeds
//                the DUT; a lane-queue reference model predicts every output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_unpacker;

  localparam int IN_BIT  = 64;
  localparam int OUT_BIT = 16;
  localparam int CNT_BIT = 4;
  localparam int RATIO   = IN_BIT / OUT_BIT;
  localparam int CNT_MOD = 1 << CNT_BIT;

  logic               rclk = 1'b0;
  logic               rrst = 1'b1;
  logic               fifo_ren;
  logic [IN_BIT-1:0]  fifo_rdata = '0;
  logic               fifo_rempty = 1'b1;
  logic               flush = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [OUT_BIT-1:0] out_data;
  logic               out_last;
  logic [CNT_BIT-1:0] word_cnt;

  always #5 rclk = ~rclk;

  fifo_rd_unpacker #(
    .IN_BIT  (IN_BIT),
    .OUT_BIT (OUT_BIT),
    .CNT_BIT (CNT_BIT)
  ) dut (
    .rclk        (rclk),
    .rrst        (rrst),
    .fifo_ren    (fifo_ren),
    .fifo_rdata  (fifo_rdata),
    .fifo_rempty (fifo_rempty),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .word_cnt    (word_cnt)
  );

  typedef struct {
    logic [OUT_BIT-1:0] data;
    int                 idx;
  } lane_t;

  logic [IN_BIT-1:0] src_q[$];   // words held by the upstream FIFO
  lane_t             buf_q[$];   // lanes the DUT should currently hold, in order
  bit                force_empty = 1'b0;
  bit                m_inflight  = 1'b0;
  int                m_cnt       = 0;
  int                n_cmp       = 0;
  int                n_err       = 0;

  // Values sampled in the last cycle
  bit                 s_valid;
  bit                 s_ren;
  logic [OUT_BIT-1:0] s_data;
  logic [CNT_BIT-1:0] s_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic update_empty();
    fifo_rempty = force_empty || (src_q.size() == 0);
  endtask

  // One clock cycle: compare at the falling edge, then advance FIFO and model.
  task automatic cycle();
    bit ren, emp, hs, pop;
    int words, exp_ren;
    update_empty();
    @(negedge rclk);
    words   = (buf_q.size() + RATIO - 1) / RATIO;
    hs      = (buf_q.size() > 0) && out_ready;
    pop     = hs && (buf_q[0].idx == RATIO - 1);
    exp_ren = (!flush && !rrst && (words - int'(pop) + int'(m_inflight)) < 2) ? 1 : 0;
    check("fifo_ren", fifo_ren, exp_ren);
    check("out_valid", out_valid, buf_q.size() > 0);
    if (buf_q.size() > 0) begin
      check("out_data", out_data, buf_q[0].data);
      check("out_last", out_last, buf_q[0].idx == RATIO - 1);
    end else begin
      check("out_data_idle", out_data, 0);
      check("out_last_idle", out_last, 0);
    end
    check("word_cnt", word_cnt, m_cnt % CNT_MOD);
    s_valid = out_valid;
    s_ren   = fifo_ren;
    s_data  = out_data;
    s_cnt   = word_cnt;
    ren     = fifo_ren;
    emp     = fifo_rempty;
    @(posedge rclk);
    #1;
    if (flush) begin
      buf_q.delete();
    end else begin
      if (hs) begin
        if (buf_q[0].idx == RATIO - 1) m_cnt++;
        void'(buf_q.pop_front());
      end
      if (m_inflight) begin
        for (int i = 0; i < RATIO; i++) begin
          lane_t l;
          l.data = fifo_rdata[i*OUT_BIT +: OUT_BIT];
          l.idx  = i;
          buf_q.push_back(l);
        end
      end
    end
    m_inflight = ren && !emp;
    if (m_inflight) fifo_rdata = src_q.pop_front();
    update_empty();
  endtask

  // Asynchronous reset pulse starting just after a rising edge.
  task automatic do_reset();
    rrst = 1'b1;
    #1;
    check("rst_fifo_ren", fifo_ren, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_word_cnt", word_cnt, 0);
    repeat (2) @(posedge rclk);
    #1;
    buf_q.delete();
    m_inflight = 1'b0;
    m_cnt      = 0;
    rrst       = 1'b0;
  endtask

  initial begin
    int                 first;
    int                 nvalid;
    int                 firstv;
    int                 lastv;
    bit                 saw15;
    logic [IN_BIT-1:0]  w;
    logic [IN_BIT-1:0]  wb;
    logic [OUT_BIT-1:0] got_lanes[$];
    logic [OUT_BIT-1:0] exp_lanes[4];

    // Reset state
    #3;
    check("init_fifo_ren", fifo_ren, 0);
    check("init_out_valid", out_valid, 0);
    check("init_out_data", out_data, 0);
    check("init_word_cnt", word_cnt, 0);
    @(posedge rclk);
    #1;
    rrst = 1'b0;

    // Single word after reset release: latency and lane order
    src_q.push_back(64'h4444_3333_2222_1111);
    out_ready = 1'b1;
    first = -1;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (c == 0) check("t1_ren_cycle0", s_ren, 1);
      if (s_valid && first < 0) first = c;
      if (s_valid) got_lanes.push_back(s_data);
    end
    check("t1_latency", first, 2);
    exp_lanes = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    check("t1_lane_count", got_lanes.size(), 4);
    for (int i = 0; i < 4 && i < got_lanes.size(); i++) check("t1_lane", got_lanes[i], exp_lanes[i]);
    check("t1_word_cnt", word_cnt, 1);

    // Three words back to back: 12 lanes without a gap
    for (int i = 0; i < 3; i++) src_q.push_back({$urandom, $urandom});
    nvalid = 0; firstv = -1; lastv = -1;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (s_valid) begin
        nvalid++;
        if (firstv < 0) firstv = c;
        lastv = c;
      end
    end
    check("t2_lanes", nvalid, 12);
    check("t2_no_gap", lastv - firstv + 1, 12);
    check("t2_word_cnt", word_cnt, 4);

    // Back-pressure: buffer saturates, data held on lane 0 of the first word
    out_ready = 1'b0;
    w = {$urandom, $urandom};
    src_q.push_back(w);
    for (int i = 0; i < 3; i++) src_q.push_back({$urandom, $urandom});
    for (int c = 0; c < 14; c++) cycle();
    check("t3_ren_held_low", fifo_ren, 0);
    check("t3_data_held", out_data, w[OUT_BIT-1:0]);
    check("t3_fifo_left", src_q.size(), 2);
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) cycle();
    check("t3_drained", out_valid, 0);

    // Flush in the cycle after a read is accepted
    w  = {$urandom, $urandom};
    wb = {$urandom, $urandom};
    src_q.push_back(w);
    src_q.push_back(wb);
    cycle();
    flush = 1'b1;
    out_ready = 1'b0;
    cycle();
    flush = 1'b0;
    out_ready = 1'b1;
    cycle();
    check("t4_valid_after_flush", s_valid, 0);
    first = -1;
    for (int c = 0; c < 10 && first < 0; c++) begin
      cycle();
      if (s_valid) begin
        first = c;
        check("t4_next_lane", s_data, wb[OUT_BIT-1:0]);
      end
    end
    check("t4_delivered", first >= 0, 1);
    for (int c = 0; c < 10; c++) cycle();

    // Empty FIFO: nothing captured
    force_empty = 1'b1;
    src_q.push_back({$urandom, $urandom});
    nvalid = 0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (s_valid) nvalid++;
    end
    check("t5_no_valid_when_empty", nvalid, 0);
    force_empty = 1'b0;
    src_q.push_back({$urandom, $urandom});
    first = -1;
    for (int c = 0; c < 30 && first < 0; c++) begin
      cycle();
      if (buf_q.size() > 0 && buf_q[0].idx == 2) first = c;
    end
    check("t5_reached_lane2", first >= 0, 1);
    do_reset();
    for (int c = 0; c < 12; c++) cycle();

    // Word counter wraps 15 -> 0
    do_reset();
    src_q.delete();
    for (int i = 0; i < CNT_MOD + 1; i++) src_q.push_back({$urandom, $urandom});
    out_ready = 1'b1;
    saw15 = 1'b0;
    for (int c = 0; c < 200 && m_cnt < CNT_MOD; c++) begin
      cycle();
      if (s_cnt == 4'd15) saw15 = 1'b1;
    end
    check("t6_saw_15", saw15, 1);
    check("t6_wrap_to_0", word_cnt, 0);
    for (int c = 0; c < 10; c++) cycle();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) src_q.push_back({$urandom, $urandom});
      force_empty = ($urandom_range(0, 7) == 0);
      flush       = ($urandom_range(0, 40) == 0);
      out_ready   = flush ? 1'b0 : ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 300) == 0) begin
        flush = 1'b0;
        do_reset();
      end
      cycle();
    end
    flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
